fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Fetch stage of the 5-stage ARM pipeline, directly upstream of the hazard unit's stall/flush consumers.
- Owns PCF, the instruction-memory request handshake and the F/D pipeline register.
- Consumes StallF, StallD, FlushD and BranchTakenE, plus the E-stage branch target.
- Reports instruction-memory wait stalls so the hazard unit can freeze F/D and bubble E.

Parameters:
- XLEN, 32, width of address and instruction words.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- StallF  in  1  from hazard unit: hold PCF, issue no new request
- StallD  in  1  from hazard unit: hold the F/D register
- FlushD  in  1  from hazard unit: bubble the F/D register
- BranchTakenE  in  1  branch resolved taken in E
- BranchTargetE  in  XLEN  redirect address
- IMemReq  out  1  instruction fetch request
- IMemAddr  out  XLEN  fetch address (word aligned)
- IMemRdy  in  1  memory accepts request and returns data this cycle
- IMemRData  in  XLEN  fetched instruction
- IMissStallF  out  1  IMemReq & ~IMemRdy, to hazard unit
- InstrD  out  XLEN  decode-stage instruction
- PCPlus8D  out  XLEN  fetch PC + 8 (ARM R15 value in D)
- ValidD  out  1  InstrD is a real instruction

Behaviour:
- Reset (async, reset=0): PCF=RESET_PC, state=BOOT, InstrD=0, PCPlus8D=0, ValidD=0, hold buffer empty, IMemReq=0.
- FSM states:
  - BOOT: one idle cycle after reset release, then FETCH.
  - FETCH: normal operation.
  - DRAIN: discarding the in-flight request after a redirect.
- Request issue (FETCH): IMemReq=1 and IMemAddr=PCF when a request is already in flight, or when ~StallF and the hold buffer is empty.
- Handshake: once IMemReq is raised, IMemAddr stays stable and IMemReq stays high until the cycle IMemRdy=1. Zero-wait completion in the same cycle is legal.
- Completion (IMemReq & IMemRdy in FETCH):
  - PCF <= PCF+4.
  - If ~StallD: InstrD <= IMemRData, PCPlus8D <= PCF+8, ValidD <= 1.
  - If StallD: data and PCF+8 go into a 1-entry hold buffer.
- Hold buffer: drains into F/D on the first cycle with ~StallD; no new request is issued while it is full.
- No completion and ~StallD: F/D loads a bubble (ValidD=0, InstrD=0).
- BranchTakenE:
  - Highest priority; overrides StallF.
  - Clears the hold buffer.
  - No request in flight: PCF <= BranchTargetE; the next request uses the target.
  - Request in flight without IMemRdy: target latched, state -> DRAIN.
  - In DRAIN: IMemReq is held until IMemRdy, the data is discarded, then PCF <= latched target and state -> FETCH.
  - Completion in the branch cycle itself: data discarded; PCF <= BranchTargetE.
- F/D register priority: FlushD > StallD > load. FlushD forces ValidD=0, InstrD=0, PCPlus8D=0.
- PCF wraps modulo 2^XLEN. BranchTargetE[1:0] is ignored (forced 0).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs FetchCount (32 bits) and IMissCycles (32 bits).
  - FetchCount increments on each non-discarded completion.
  - IMissCycles increments each cycle IMissStallF=1.
  - Both reset to 0 and saturate at all-ones.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared package arm_pipe_pkg:
  - XLEN
  - state encoding (BOOT=2'd0, FETCH=2'd1, DRAIN=2'd2)
  - ARM_PC_OFFSET=8
- One natural sub-module, fetch_hold_buf: 1-entry valid/data/pc register with load/drain/clear.

Test Plan:
- Reset release, IMemRdy tied 1, no stalls -> IMemAddr 0x0 (after BOOT), 0x4, 0x8; ValidD=1 with InstrD matching each word; PCPlus8D 0x8, 0xC, 0x10.
- IMemRdy low 3 cycles on address 0x8 -> IMissStallF=1 for 3 cycles, IMemAddr held at 0x8, then PCF=0xC.
- BranchTakenE with target 0x100 while a request to 0x10 waits 2 cycles -> state DRAIN, 0x10 data never reaches D, next IMemAddr=0x100.
- StallD high on the completion cycle at 0x4 -> data goes to the hold buffer and no new request is issued; after StallD drops, InstrD=word@0x4, then the fetch of 0x8 follows.
- FlushD and StallD both high -> ValidD=0 and InstrD=0 the next cycle.
- reset pulled low while waiting in DRAIN -> all outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared constants and state encoding for the ARM pipeline fetch stage
package arm_pipe_pkg;

  localparam int XLEN          = 32;
  localparam int ARM_PC_OFFSET = 8;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry instruction/pc holding register for fetches completed under StallD
module fetch_hold_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_pc;

  // Clear (redirect) beats load, load beats drain; load and drain never coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - ARM fetch stage: PCF, imem handshake, F/D register; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage #(
  parameter int              XLEN     = arm_pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            BranchTakenE,
  input  logic [XLEN-1:0] BranchTargetE,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemRdy,
  input  logic [XLEN-1:0] IMemRData,
  output logic            IMissStallF,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     FetchCount,
  output logic [31:0]     IMissCycles,
`endif
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCPlus8D,
  output logic            ValidD
);

  import arm_pipe_pkg::*;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_target;
  logic            r_pending;
  logic [XLEN-1:0] r_instr_d;
  logic [XLEN-1:0] r_pc8_d;
  logic            r_valid_d;

  logic            w_req;
  logic            w_done;
  logic            w_fetch_ok;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_pc8;
  logic [XLEN-1:0] w_tgt;
  logic            w_hold_valid;
  logic [XLEN-1:0] w_hold_data;
  logic [XLEN-1:0] w_hold_pc;

  // A pending request must be finished; a new one needs ~StallF and room to park its data.
  assign w_req = ((r_state == FETCH) && (r_pending || (!StallF && !w_hold_valid)))
               || (r_state == DRAIN);
  assign w_done     = w_req & IMemRdy;
  assign w_fetch_ok = (r_state == FETCH) & w_done & ~BranchTakenE;
  assign w_pc4      = r_pcf + XLEN'(4);
  assign w_pc8      = r_pcf + XLEN'(ARM_PC_OFFSET);
  assign w_tgt      = BranchTargetE & ~XLEN'(3);

  assign IMemReq     = w_req;
  assign IMemAddr    = r_pcf;
  assign IMissStallF = w_req & ~IMemRdy;
  assign InstrD      = r_instr_d;
  assign PCPlus8D    = r_pc8_d;
  assign ValidD      = r_valid_d;

  fetch_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_fetch_ok & StallD),
    .i_drain (w_hold_valid & ~StallD),
    .i_clear (BranchTakenE),
    .i_data  (IMemRData),
    .i_pc    (w_pc8),
    .o_valid (w_hold_valid),
    .o_data  (w_hold_data),
    .o_pc    (w_hold_pc)
  );

  // Fetch FSM: PC sequencing, redirect handling and discard of redirected in-flight requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= BOOT;
      r_pcf     <= RESET_PC;
      r_target  <= '0;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= FETCH;
          if (BranchTakenE) r_pcf <= w_tgt;
        end
        FETCH: begin
          if (BranchTakenE) begin
            r_pending <= 1'b0;
            if (w_req && !IMemRdy) begin
              r_target <= w_tgt;
              r_state  <= DRAIN;
            end else begin
              r_pcf <= w_tgt;
            end
          end else if (w_done) begin
            r_pcf     <= w_pc4;
            r_pending <= 1'b0;
          end else begin
            r_pending <= w_req;
          end
        end
        DRAIN: begin
          if (IMemRdy) begin
            r_pcf   <= BranchTakenE ? w_tgt : r_target;
            r_state <= FETCH;
          end else if (BranchTakenE) begin
            r_target <= w_tgt;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  // F/D register: flush beats stall, parked data beats a fresh completion, otherwise a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_d <= '0;
      r_pc8_d   <= '0;
      r_valid_d <= 1'b0;
    end else if (FlushD) begin
      r_instr_d <= '0;
      r_pc8_d   <= '0;
      r_valid_d <= 1'b0;
    end else if (!StallD) begin
      if (w_hold_valid) begin
        r_instr_d <= w_hold_data;
        r_pc8_d   <= w_hold_pc;
        r_valid_d <= 1'b1;
      end else if (w_fetch_ok) begin
        r_instr_d <= IMemRData;
        r_pc8_d   <= w_pc8;
        r_valid_d <= 1'b1;
      end else begin
        r_instr_d <= '0;
        r_valid_d <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating counters of delivered fetches and imem wait cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_fetch_ok && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (IMissStallF && (r_miss_cnt != '1))  r_miss_cnt  <= r_miss_cnt + 32'd1;
    end
  end

  assign FetchCount  = r_fetch_cnt;
  assign IMissCycles = r_miss_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        BranchTakenE = 1'b0;
  logic [31:0] BranchTargetE = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemRdy = 1'b1;
  logic [31:0] IMemRData;
  logic        IMissStallF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] IMissCycles;
`endif

  always #5 clk = ~clk;

  // Instruction memory image: word at address A is 0xE3A00000 ^ A.
  assign IMemRData = 32'hE3A0_0000 ^ IMemAddr;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .IMemReq       (IMemReq),
    .IMemAddr      (IMemAddr),
    .IMemRdy       (IMemRdy),
    .IMemRData     (IMemRData),
    .IMissStallF   (IMissStallF),
`ifdef FETCH_PERF_CNT_EN
    .FetchCount    (FetchCount),
    .IMissCycles   (IMissCycles),
`endif
    .InstrD        (InstrD),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic sd_q    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc8);
    exp_t e;
    e.instr = instr;
    e.pc8   = pc8;
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(posedge clk) sd_q <= StallD;

  // Monitor: every freshly loaded valid F/D entry must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset && ValidD && !sd_q) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got %h expected none", InstrD);
      end else begin
        e = exp_q.pop_front();
        chk("InstrD", InstrD, e.instr);
        chk("PCPlus8D", PCPlus8D, e.pc8);
      end
    end
  end

  initial begin
    // reset state
    smp();
    chk("rst_req", {31'd0, IMemReq}, 32'd0);
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_pc8", PCPlus8D, 32'h0);

    // BOOT idle cycle, then straight-line fetch
    nxt(); reset = 1'b1;
    smp(); chk("boot_idle", {31'd0, IMemReq}, 32'd0);
    nxt(); push(32'hE3A0_0000, 32'h8);
    smp(); chk("req0", {31'd0, IMemReq}, 32'd1); chk("addr0", IMemAddr, 32'h0);
    nxt(); push(32'hE3A0_0004, 32'hC);
    smp(); chk("addr4", IMemAddr, 32'h4);

    // three wait cycles on 0x8
    nxt(); IMemRdy = 1'b0;
    smp(); chk("miss_a", {31'd0, IMissStallF}, 32'd1); chk("miss_addr_a", IMemAddr, 32'h8);
    for (int i = 0; i < 2; i++) begin
      nxt();
      smp(); chk("miss_b", {31'd0, IMissStallF}, 32'd1); chk("miss_addr_b", IMemAddr, 32'h8);
    end
    nxt(); IMemRdy = 1'b1; push(32'hE3A0_0008, 32'h10);
    smp(); chk("miss_done", {31'd0, IMissStallF}, 32'd0); chk("addr8", IMemAddr, 32'h8);
    nxt(); push(32'hE3A0_000C, 32'h14);
    smp(); chk("pcf_after_miss", IMemAddr, 32'hC);

    // redirect to 0x100 while 0x10 is waiting
    nxt(); IMemRdy = 1'b0;
    smp(); chk("addr10", IMemAddr, 32'h10);
    nxt(); BranchTakenE = 1'b1; BranchTargetE = 32'h100;
    smp(); chk("br_miss", {31'd0, IMissStallF}, 32'd1);
    nxt(); BranchTakenE = 1'b0;
    smp(); chk("drain_req", {31'd0, IMemReq}, 32'd1); chk("drain_addr", IMemAddr, 32'h10);
    nxt(); IMemRdy = 1'b1;
    smp(); chk("drain_done_addr", IMemAddr, 32'h10);
    nxt(); push(32'hE3A0_0100, 32'h108);
    smp(); chk("addr100", IMemAddr, 32'h100);
    nxt(); push(32'hE3A0_0104, 32'h10C);
    smp(); chk("addr104", IMemAddr, 32'h104);

    // enter DRAIN again, then assert reset asynchronously
    nxt(); IMemRdy = 1'b0; BranchTakenE = 1'b1; BranchTargetE = 32'h203;
    smp(); chk("addr108", IMemAddr, 32'h108);
    nxt(); BranchTakenE = 1'b0;
    smp(); chk("drain2_req", {31'd0, IMemReq}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_req", {31'd0, IMemReq}, 32'd0);
    chk("arst_addr", IMemAddr, 32'h0);
    chk("arst_valid", {31'd0, ValidD}, 32'd0);
    chk("arst_instr", InstrD, 32'h0);
    chk("arst_pc8", PCPlus8D, 32'h0);
    nxt();
    nxt(); reset = 1'b1; IMemRdy = 1'b1;
    smp(); chk("boot2_idle", {31'd0, IMemReq}, 32'd0);
    nxt(); push(32'hE3A0_0000, 32'h8);
    smp(); chk("restart_addr", IMemAddr, 32'h0);

    // StallD on the completion of 0x4 parks it in the hold buffer
    nxt(); StallD = 1'b1; push(32'hE3A0_0004, 32'hC);
    smp(); chk("hold_addr", IMemAddr, 32'h4);
    nxt();
    smp(); chk("hold_no_req", {31'd0, IMemReq}, 32'd0); chk("hold_instr", InstrD, 32'hE3A0_0000);
    nxt(); StallD = 1'b0;
    smp(); chk("hold_drain_no_req", {31'd0, IMemReq}, 32'd0);
    nxt(); push(32'hE3A0_0008, 32'h10);
    smp(); chk("after_hold_req", {31'd0, IMemReq}, 32'd1); chk("after_hold_addr", IMemAddr, 32'h8);

    // FlushD together with StallD
    nxt(); StallD = 1'b1; FlushD = 1'b1; IMemRdy = 1'b0;
    smp(); chk("addrC", IMemAddr, 32'hC);
    nxt(); StallD = 1'b0; FlushD = 1'b0; IMemRdy = 1'b1; push(32'hE3A0_000C, 32'h14);
    smp();
    chk("flush_valid", {31'd0, ValidD}, 32'd0);
    chk("flush_instr", InstrD, 32'h0);
    chk("flush_pc8", PCPlus8D, 32'h0);
    chk("pending_addr", IMemAddr, 32'hC);
    nxt(); StallF = 1'b1;
    smp(); chk("stallf_no_req", {31'd0, IMemReq}, 32'd0);
    nxt(); StallF = 1'b0; push(32'hE3A0_0010, 32'h18);
    smp(); chk("addr10b", IMemAddr, 32'h10);

    // redirect under StallF to an unaligned target near the top; PC wraps
    nxt(); StallF = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 32'hFFFF_FFFE;
    smp(); chk("br_stallf_no_req", {31'd0, IMemReq}, 32'd0);
    nxt(); StallF = 1'b0; BranchTakenE = 1'b0; push(32'h1C5F_FFFC, 32'h4);
    smp(); chk("addr_top", IMemAddr, 32'hFFFF_FFFC);
    nxt(); StallF = 1'b1;
    smp(); chk("pcf_wrap", IMemAddr, 32'h0);

    repeat (3) nxt();
    smp(); chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
